// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - Hazard, forwarding and mult/div sequencing control for a 5-stage MIPS pipeline
module hazard_controller #(
    parameter int MULDIV_CYCLES = 32,
    parameter int CNT_W         = 6
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  RsD,
    input  logic [4:0]  RtD,
    input  logic [4:0]  RsE,
    input  logic [4:0]  RtE,
    input  logic [4:0]  WriteRegE,
    input  logic [4:0]  WriteRegM,
    input  logic [4:0]  WriteRegW,
    input  logic        RegWriteE,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        MemtoRegE,
    input  logic        MemtoRegM,
    input  logic        BranchD,
    input  logic        MulDivE,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        ForwardAD,
    output logic        ForwardBD,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        FlushE,
    output logic        MulDivBusy,
    output logic        MulDivDone,
    output logic [31:0] StallCount
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Entry cycle plus BUSY cycles counting CNT_LOAD..0 gives MULDIV_CYCLES stalled cycles.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 2);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        stall_count_q, stall_count_d;
    logic               lwstall, brstall, mdstall;

    always_comb begin
        ForwardAE = 2'd0;
        ForwardBE = 2'd0;
        if (RegWriteM && (WriteRegM == RsE) && (RsE != 5'd0))
            ForwardAE = 2'd2;
        else if (RegWriteW && (WriteRegW == RsE) && (RsE != 5'd0))
            ForwardAE = 2'd1;
        if (RegWriteM && (WriteRegM == RtE) && (RtE != 5'd0))
            ForwardBE = 2'd2;
        else if (RegWriteW && (WriteRegW == RtE) && (RtE != 5'd0))
            ForwardBE = 2'd1;
    end

    assign ForwardAD = RegWriteM && (WriteRegM == RsD) && (RsD != 5'd0);
    assign ForwardBD = RegWriteM && (WriteRegM == RtD) && (RtD != 5'd0);

    assign lwstall = MemtoRegE && (RtE != 5'd0) && ((RtE == RsD) || (RtE == RtD));

    assign brstall = BranchD &&
        ((RegWriteE && (WriteRegE != 5'd0) && ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
         (MemtoRegM && (WriteRegM != 5'd0) && ((WriteRegM == RsD) || (WriteRegM == RtD))));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mdstall    = 1'b0;
        MulDivDone = 1'b0;
        case (state_q)
            IDLE: begin
                if (MulDivE) begin
                    mdstall = 1'b1;
                    cnt_d   = CNT_LOAD;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                mdstall = 1'b1;
                if (cnt_q == '0)
                    state_d = DONE;
                else
                    cnt_d = cnt_q - CNT_W'(1);
            end
            DONE: begin
                // MulDivE here still belongs to the op that is just leaving E.
                MulDivDone = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign MulDivBusy = (state_q != IDLE) || MulDivE;
    assign StallF     = lwstall || brstall || mdstall;
    assign StallD     = StallF;
    assign StallE     = mdstall;
    assign FlushE     = (lwstall || brstall) && !mdstall;

    assign stall_count_d = (StallF && (stall_count_q != 32'hFFFF_FFFF))
                         ? stall_count_q + 32'd1 : stall_count_q;
    assign StallCount    = stall_count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            stall_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - Randomized and directed self-checking bench for hazard_controller
module tb_hazard_controller;

    localparam int MD = 4;

    logic        clk;
    logic        reset_n;
    logic [4:0]  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic        RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD, MulDivE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        ForwardAD, ForwardBD, StallF, StallD, StallE, FlushE, MulDivBusy, MulDivDone;
    logic [31:0] StallCount;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: stalled cycles still owed by the current op, a pending DONE cycle, the stall tally.
    int          m_left;
    bit          m_done;
    logic [31:0] m_cnt;

    hazard_controller #(.MULDIV_CYCLES(MD), .CNT_W(6)) dut (
        .clk(clk), .reset_n(reset_n),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD), .MulDivE(MulDivE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .FlushE(FlushE),
        .MulDivBusy(MulDivBusy), .MulDivDone(MulDivDone), .StallCount(StallCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit hits(input logic we, input logic [4:0] dst, input logic [4:0] src);
        return we && (dst != 5'd0) && (dst == src);
    endfunction

    function automatic logic [1:0] fwd(input logic [4:0] src);
        if (hits(RegWriteM, WriteRegM, src)) return 2'd2;
        if (hits(RegWriteW, WriteRegW, src)) return 2'd1;
        return 2'd0;
    endfunction

    function automatic bit exp_hazard();
        bit lw, br;
        lw = hits(MemtoRegE, RtE, RsD) || hits(MemtoRegE, RtE, RtD);
        br = BranchD && (hits(RegWriteE, WriteRegE, RsD) || hits(RegWriteE, WriteRegE, RtD) ||
                         hits(MemtoRegM, WriteRegM, RsD) || hits(MemtoRegM, WriteRegM, RtD));
        return lw || br;
    endfunction

    function automatic bit exp_md();
        if (m_done) return 1'b0;
        if (m_left > 0) return 1'b1;
        return MulDivE;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_left = 0;
            m_done = 0;
            m_cnt  = 32'd0;
        end else begin
            if ((exp_hazard() || exp_md()) && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            if (m_done) m_done = 0;
            else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_done = 1;
            end else if (MulDivE) m_left = MD - 1;
        end
    end

    always @(negedge clk) begin
        bit hz, md;
        hz = exp_hazard();
        md = exp_md();
        check("ForwardAE", 32'(ForwardAE), 32'(fwd(RsE)));
        check("ForwardBE", 32'(ForwardBE), 32'(fwd(RtE)));
        check("ForwardAD", 32'(ForwardAD), 32'(hits(RegWriteM, WriteRegM, RsD)));
        check("ForwardBD", 32'(ForwardBD), 32'(hits(RegWriteM, WriteRegM, RtD)));
        check("StallF", 32'(StallF), 32'(hz || md));
        check("StallD", 32'(StallD), 32'(hz || md));
        check("StallE", 32'(StallE), 32'(md));
        check("FlushE", 32'(FlushE), 32'(hz && !md));
        check("MulDivBusy", 32'(MulDivBusy), 32'(m_done || m_left > 0 || MulDivE));
        check("MulDivDone", 32'(MulDivDone), 32'(m_done));
        check("StallCount", StallCount, m_cnt);
    end

    task automatic clear_inputs();
        {RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW} = '0;
        {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD, MulDivE} = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        clear_inputs();
        step();
        step();
        #1;
        check("reset_count", StallCount, 32'd0);
        check("reset_busy", 32'(MulDivBusy), 32'd0);
        check("reset_stallE", 32'(StallE), 32'd0);
        reset_n = 1'b1;

        // Forwarding priority and $0 suppression
        step();
        RsE = 5; RtE = 6; RegWriteM = 1; WriteRegM = 5; RegWriteW = 1; WriteRegW = 6;
        #1;
        check("fwd_AE_M", 32'(ForwardAE), 32'd2);
        check("fwd_BE_W", 32'(ForwardBE), 32'd1);
        WriteRegW = 5;
        #1;
        check("fwd_AE_prio", 32'(ForwardAE), 32'd2);
        RsE = 0; WriteRegM = 0; WriteRegW = 0;
        #1;
        check("fwd_AE_zero", 32'(ForwardAE), 32'd0);

        // Load-use
        step();
        clear_inputs();
        MemtoRegE = 1; RtE = 7; RsD = 7;
        #1;
        check("lw_StallF", 32'(StallF), 32'd1);
        check("lw_StallD", 32'(StallD), 32'd1);
        check("lw_FlushE", 32'(FlushE), 32'd1);
        check("lw_StallE", 32'(StallE), 32'd0);
        check("lw_cnt0", StallCount, 32'd0);
        step();
        check("lw_cnt1", StallCount, 32'd1);
        RtE = 0;
        #1;
        check("lw_r0", 32'(StallF), 32'd0);

        // Branch dependencies
        clear_inputs();
        BranchD = 1; RegWriteE = 1; WriteRegE = 3; RtD = 3;
        #1;
        check("br_E_StallF", 32'(StallF), 32'd1);
        check("br_E_FlushE", 32'(FlushE), 32'd1);
        step();
        RegWriteE = 0; MemtoRegM = 1; WriteRegM = 3;
        #1;
        check("br_M_load", 32'(StallF), 32'd1);
        step();
        MemtoRegM = 0; RegWriteM = 1;
        #1;
        check("br_M_alu_nostall", 32'(StallF), 32'd0);
        check("br_M_alu_fwdBD", 32'(ForwardBD), 32'd1);
        check("br_cnt", StallCount, 32'd3);

        // Mult/div with a coincident load-use hazard that must not flush
        step();
        clear_inputs();
        MulDivE = 1; MemtoRegE = 1; RtE = 7; RsD = 7;
        for (int k = 1; k <= MD; k++) begin
            #1;
            check("md_StallE", 32'(StallE), 32'd1);
            check("md_StallF", 32'(StallF), 32'd1);
            check("md_FlushE", 32'(FlushE), 32'd0);
            check("md_Done_low", 32'(MulDivDone), 32'd0);
            step();
        end
        #1;
        check("md_Done", 32'(MulDivDone), 32'd1);
        check("md_release", 32'(StallE), 32'd0);
        check("md_cnt", StallCount, 32'd7);
        step();
        #1;
        check("md_b2b", 32'(StallE), 32'd1);
        MulDivE = 0; MemtoRegE = 0;
        repeat (MD + 3) step();
        check("md_idle", 32'(MulDivBusy), 32'd0);

        // Reset during BUSY
        MulDivE = 1;
        step();
        MulDivE = 0;
        #1;
        check("rst_pre_busy", 32'(MulDivBusy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst_busy", 32'(MulDivBusy), 32'd0);
        check("rst_stallE", 32'(StallE), 32'd0);
        check("rst_cnt", StallCount, 32'd0);
        step();
        reset_n = 1'b1;
        repeat (3) step();
        check("rst_idle", 32'(MulDivBusy), 32'd0);
        check("rst_idle_stall", 32'(StallF), 32'd0);

        // Saturation from a preloaded tally
        force dut.stall_count_q = 32'hFFFF_FFFD;
        m_cnt = 32'hFFFF_FFFD;
        #1;
        release dut.stall_count_q;
        MemtoRegE = 1; RtE = 9; RtD = 9;
        repeat (5) step();
        check("sat_hold", StallCount, 32'hFFFF_FFFF);
        clear_inputs();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            step();
            RsD = 5'($urandom_range(0, 3)); RtD = 5'($urandom_range(0, 3));
            RsE = 5'($urandom_range(0, 3)); RtE = 5'($urandom_range(0, 3));
            WriteRegE = 5'($urandom_range(0, 3)); WriteRegM = 5'($urandom_range(0, 3));
            WriteRegW = 5'($urandom_range(0, 3));
            RegWriteE = 1'($urandom); RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
            MemtoRegE = 1'($urandom_range(0, 3) == 0); MemtoRegM = 1'($urandom_range(0, 3) == 0);
            BranchD = 1'($urandom_range(0, 3) == 0);
            MulDivE = 1'($urandom_range(0, 11) == 0);
            if (i % 700 == 350) begin
                reset_n = 1'b0;
                #2;
                reset_n = 1'b1;
            end
        end
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Hazard and sequencing controller for the 5-stage MIPS pipeline.
- Drives the execute-stage forwarding selects (ForwardAE/ForwardBE), decode-stage branch forwarding, and the stall/flush signals for fetch, decode and execute.
- Sequences multi-cycle mult/div ops by holding the execute stage for a fixed cycle count.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- MULDIV_CYCLES, 32, total cycles a mult/div op occupies E; must be >= 2.
- CNT_W, 6, width of the mult/div down-counter; must satisfy 2^CNT_W > MULDIV_CYCLES.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- RsD, RtD  in  5  source registers of the instruction in D
- RsE, RtE  in  5  source registers of the instruction in E
- WriteRegE, WriteRegM, WriteRegW  in  5  destination registers in E/M/W
- RegWriteE, RegWriteM, RegWriteW  in  1  destination write enables
- MemtoRegE, MemtoRegM  in  1  load in E/M
- BranchD  in  1  branch resolved in D
- MulDivE  in  1  instruction in E is mult/div
- ForwardAE, ForwardBE  out  2  E operand select: 0 = register file, 1 = ResultW, 2 = ALUOutM
- ForwardAD, ForwardBD  out  1  D comparator operand from ALUOutM
- StallF, StallD  out  1  hold PC and the F/D register
- StallE  out  1  hold the D/E register
- FlushE  out  1  clear the D/E register (bubble)
- MulDivBusy  out  1  sequencer not IDLE
- MulDivDone  out  1  one-cycle pulse when the op releases E
- StallCount  out  32  saturating count of cycles with StallF=1

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, counter=0, StallCount=0.
  - Combinational outputs follow their equations with state=IDLE.
- Register $0 never matches: any compare against 0 is false.
- ForwardAE:
  - =2 if RegWriteM & WriteRegM==RsE & RsE!=0.
  - else =1 if RegWriteW & WriteRegW==RsE & RsE!=0.
  - else 0.
  - M takes priority over W.
- ForwardBE: same rule using RtE.
- ForwardAD = RegWriteM & WriteRegM==RsD & RsD!=0. ForwardBD uses RtD likewise.
- lwstall = MemtoRegE & RtE!=0 & (RtE==RsD | RtE==RtD).
- brstall = BranchD & ((RegWriteE & WriteRegE!=0 & WriteRegE∈{RsD,RtD}) | (MemtoRegM & WriteRegM!=0 & WriteRegM∈{RsD,RtD})).
- Mult/div sequencer states: IDLE, BUSY, DONE.
  - IDLE: MulDivE=1 gives mdstall=1 this cycle, loads counter=MULDIV_CYCLES-2, next=BUSY. Otherwise stays IDLE.
  - BUSY: mdstall=1. If counter==0, next=DONE; else counter decrements.
  - DONE: mdstall=0, MulDivDone=1, next=IDLE. MulDivE is ignored in DONE (same instruction leaving E).
  - Net stall length of a mult/div is exactly MULDIV_CYCLES cycles.
  - A back-to-back mult/div arriving in the cycle after DONE starts a fresh sequence.
- MulDivBusy = (state!=IDLE) | (state==IDLE & MulDivE).
- Stall and flush equations:
  - StallF = StallD = lwstall | brstall | mdstall.
  - StallE = mdstall.
  - FlushE = (lwstall | brstall) & ~mdstall. Never flush while E is held.
- Forwarding outputs remain valid during mdstall (they are purely combinational on inputs).
- StallCount increments on each rising edge where StallF=1 and saturates at 32'hFFFFFFFF.
- Reset asserted mid-BUSY: immediately returns to IDLE with all stalls low, counter=0, StallCount=0.

Test Plan:
- Forwarding: RsE=5, RtE=6, RegWriteM=1, WriteRegM=5, RegWriteW=1, WriteRegW=6 -> ForwardAE=2, ForwardBE=1. Then WriteRegW=5 -> ForwardAE stays 2. Then RsE=0 with all writes targeting 0 -> ForwardAE=0.
- Load-use: MemtoRegE=1, RtE=7, RsD=7 -> StallF=StallD=FlushE=1, StallE=0, StallCount increments by 1. Same with RtE=0 -> no stall.
- Branch: BranchD=1, RegWriteE=1, WriteRegE=3, RtD=3 -> StallF=1, FlushE=1. Same with MemtoRegM=1, WriteRegM=3 and RegWriteE=0 -> stall. With RegWriteM=1, WriteRegM=3, MemtoRegM=0 -> no stall, ForwardBD=1.
- Mult/div, MULDIV_CYCLES=4: MulDivE=1 held -> StallE/StallF high for exactly 4 cycles, MulDivDone pulses on cycle 5, FlushE=0 throughout even with lwstall forced; StallCount=4.
- Reset in BUSY: reset_n=0 on cycle 2 of a 32-cycle op -> MulDivBusy=0 and StallE=0 asynchronously, StallCount=0; after release with MulDivE=0, state stays IDLE.
- Saturation: preload via 2^32+ stall cycles (or a forced counter value in simulation) -> StallCount holds 32'hFFFFFFFF under continued stall.
